// File: rtl/mem_trace_pkg.sv
// Shared widths, FSM state encoding and per-lane request record for the memory trace driver.
package mem_trace_pkg;

   localparam int ADDR_W  = 64;
   localparam int DATA_W  = 64;
   localparam int SIZE_W  = 32;
   localparam int CYCLE_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ISSUE,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] address;
      logic              is_store;
      logic [SIZE_W-1:0] size;
      logic [DATA_W-1:0] data;
   } lane_t;

endpackage

// File: rtl/mem_trace_fifo.sv
// Synchronous record FIFO with occupancy count; pushes when full and pops when empty are ignored.
// The head entry is presented combinationally on pop_data whenever empty is low.
module mem_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count    = wr_ptr - rd_ptr;
   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign empty    = (wr_ptr == rd_ptr);
   assign pop_data = mem[rd_ptr[PTR_W-1:0]];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (do_push && !reset) begin
         mem[wr_ptr[PTR_W-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/mem_trace_driver.sv
// Replays buffered SIMT memory trace records, releasing each one when the free-running cycle counter
// reaches its target cycle. Optional statistics outputs are enabled by MEM_TRACE_DRIVER_STATS_EN.
//
// state | meaning
// IDLE  | FIFO empty, nothing to issue
// WAIT  | head record present, target cycle not yet reached
// ISSUE | output register holds a request awaiting req_ready
// DONE  | final record issued; absorbing until reset
module mem_trace_driver
   import mem_trace_pkg::*;
#(
   parameter int NUM_LANES  = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [CYCLE_W-1:0]            in_cycle,
   input  logic [NUM_LANES-1:0]          in_mask,
   input  logic [ADDR_W*NUM_LANES-1:0]   in_address,
   input  logic [NUM_LANES-1:0]          in_is_store,
   input  logic [SIZE_W*NUM_LANES-1:0]   in_size,
   input  logic [DATA_W*NUM_LANES-1:0]   in_data,
   input  logic                          in_last,
   output logic [NUM_LANES-1:0]          req_valid,
   output logic [ADDR_W*NUM_LANES-1:0]   req_address,
   output logic [NUM_LANES-1:0]          req_is_store,
   output logic [SIZE_W*NUM_LANES-1:0]   req_size,
   output logic [DATA_W*NUM_LANES-1:0]   req_data,
   input  logic                          req_ready,
   output logic                          done
`ifdef MEM_TRACE_DRIVER_STATS_EN
   ,
   output logic [31:0]                   stall_cycles,
   output logic [31:0]                   late_records
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [CYCLE_W-1:0]          cycle;
      logic                        last;
      logic [NUM_LANES-1:0]        mask;
      lane_t [NUM_LANES-1:0]       lanes;
   } rec_t;

   localparam int REC_W = $bits(rec_t);

   state_t                 state;
   logic [CYCLE_W-1:0]     cycle_counter;
   logic [CYCLE_W-1:0]     cycle_plus1;
   lane_t [NUM_LANES-1:0]  out_lanes;
   logic                   out_last;

   rec_t                   push_rec;
   rec_t                   head;
   logic [REC_W-1:0]       head_bits;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CNT_W-1:0]       fifo_count;
   logic [CNT_W-1:0]       occ_next;
   logic                   push;
   logic                   head_elig;
   logic                   slot_free;
   logic                   take;
   logic                   load;
   logic                   req_fire;
   state_t                 idle_or_wait;

   always_comb begin
      push_rec       = '0;
      push_rec.cycle = in_cycle;
      push_rec.last  = in_last;
      push_rec.mask  = in_mask;
      for (int g = 0; g < NUM_LANES; g++) begin
         push_rec.lanes[g].address  = in_address[ADDR_W*g +: ADDR_W];
         push_rec.lanes[g].is_store = in_is_store[g];
         push_rec.lanes[g].size     = in_size[SIZE_W*g +: SIZE_W];
         push_rec.lanes[g].data     = in_data[DATA_W*g +: DATA_W];
      end
   end

   // Acceptance depends only on occupancy, never on a same-cycle pop.
   assign in_ready = !reset && !fifo_full && (state != ST_DONE);
   assign push     = in_valid && in_ready;

   mem_trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_rec),
      .pop       (take),
      .pop_data  (head_bits),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign head = rec_t'(head_bits);

   // Deciding one cycle early lets the registered request appear exactly at head.cycle.
   assign cycle_plus1  = cycle_counter + CYCLE_W'(1);
   assign head_elig    = (cycle_plus1 >= head.cycle);
   assign req_fire     = (|req_valid) && req_ready;
   assign slot_free    = (state == ST_IDLE) || (state == ST_WAIT) ||
                         ((state == ST_ISSUE) && req_fire && !out_last);
   assign take         = slot_free && !fifo_empty && head_elig;
   assign load         = take && (|head.mask);
   assign occ_next     = fifo_count + CNT_W'(push) - CNT_W'(take);
   assign idle_or_wait = (occ_next == '0) ? ST_IDLE : ST_WAIT;

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         cycle_counter <= '0;
         req_valid     <= '0;
         out_lanes     <= '0;
         out_last      <= 1'b0;
         done          <= 1'b0;
      end else begin
         cycle_counter <= cycle_counter + CYCLE_W'(1);
         if (state != ST_DONE) begin
            if (req_fire) begin
               req_valid <= '0;
            end
            if (req_fire && out_last) begin
               state <= ST_DONE;
               done  <= 1'b1;
            end else if (load) begin
               req_valid <= head.mask;
               out_lanes <= head.lanes;
               out_last  <= head.last;
               state     <= ST_ISSUE;
            end else if (take && head.last) begin
               // Zero-mask final record: retired without ever raising req_valid.
               state <= ST_DONE;
               done  <= 1'b1;
            end else if ((state == ST_ISSUE) && !req_fire) begin
               state <= ST_ISSUE;
            end else begin
               state <= idle_or_wait;
            end
         end
      end
   end

   always_comb begin
      req_address  = '0;
      req_is_store = '0;
      req_size     = '0;
      req_data     = '0;
      for (int g = 0; g < NUM_LANES; g++) begin
         req_address[ADDR_W*g +: ADDR_W] = out_lanes[g].address;
         req_is_store[g]                 = out_lanes[g].is_store;
         req_size[SIZE_W*g +: SIZE_W]    = out_lanes[g].size;
         req_data[DATA_W*g +: DATA_W]    = out_lanes[g].data;
      end
   end

`ifdef MEM_TRACE_DRIVER_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cycles <= '0;
         late_records <= '0;
      end else begin
         if ((|req_valid) && !req_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (load && (head.cycle < cycle_plus1) && (late_records != '1)) begin
            late_records <= late_records + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_trace_driver.sv
// Scoreboard bench for mem_trace_driver: stimulus queues expected requests, a monitor checks each fire.
module tb_mem_trace_driver;

   localparam logic [63:0] NO_FIRE = '1;

   logic          clock;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_cycle;
   logic [3:0]    in_mask;
   logic [255:0]  in_address;
   logic [3:0]    in_is_store;
   logic [127:0]  in_size;
   logic [255:0]  in_data;
   logic          in_last;
   logic [3:0]    req_valid;
   logic [255:0]  req_address;
   logic [3:0]    req_is_store;
   logic [127:0]  req_size;
   logic [255:0]  req_data;
   logic          req_ready;
   logic          done;
`ifdef MEM_TRACE_DRIVER_STATS_EN
   logic [31:0]   stall_cycles;
   logic [31:0]   late_records;
`endif

   mem_trace_driver #(
      .NUM_LANES  (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_cycle     (in_cycle),
      .in_mask      (in_mask),
      .in_address   (in_address),
      .in_is_store  (in_is_store),
      .in_size      (in_size),
      .in_data      (in_data),
      .in_last      (in_last),
      .req_valid    (req_valid),
      .req_address  (req_address),
      .req_is_store (req_is_store),
      .req_size     (req_size),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .done         (done)
`ifdef MEM_TRACE_DRIVER_STATS_EN
      ,
      .stall_cycles (stall_cycles),
      .late_records (late_records)
`endif
   );

   typedef struct {
      logic [63:0]  fire;
      logic [3:0]   mask;
      logic [255:0] addr;
      logic [3:0]   st;
      logic [127:0] size;
      logic [255:0] data;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         mon_e;
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [63:0]  tb_cnt;
   logic         prev_stall;
   logic [3:0]   prev_mask;
   logic [255:0] prev_addr;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference cycle counter: zero in the first cycle after reset, then +1 per cycle.
   always @(posedge clock) begin
      if (reset) tb_cnt <= '0;
      else       tb_cnt <= tb_cnt + 64'd1;
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, tb_cnt, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else if (|req_valid) begin
         if (prev_stall) begin
            chk("hold_mask", req_valid, prev_mask);
            chk("hold_addr", req_address, prev_addr);
         end
         if (req_ready) begin
            prev_stall = 1'b0;
            if (exp_q.size() == 0) begin
               chk("unexpected_req", req_valid, 4'b0000);
            end else begin
               mon_e = exp_q.pop_front();
               chk("fire_cycle", tb_cnt, mon_e.fire);
               chk("req_mask", req_valid, mon_e.mask);
               chk("req_address", req_address, mon_e.addr);
               chk("req_is_store", req_is_store, mon_e.st);
               chk("req_size", req_size, mon_e.size);
               chk("req_data", req_data, mon_e.data);
            end
         end else begin
            prev_stall = 1'b1;
            prev_mask  = req_valid;
            prev_addr  = req_address;
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_until(input logic [63:0] n);
      for (int i = 0; i < 1000 && tb_cnt < n; i++) step();
      if (tb_cnt != n) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_until: reached cycle %0d expected %0d", tb_cnt, n);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      req_ready = 1'b0;
      step();
      step();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_req_valid", req_valid, 4'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_req_address", req_address, 256'd0);
      chk("rst_req_data", req_data, 256'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1'b1);
   endtask

   task automatic push(input logic [63:0] cyc, input logic [3:0] mask, input logic [63:0] addr0,
                       input logic last, input logic [63:0] exp_fire, output logic [63:0] fire_at);
      exp_t e;
      bit   fired;
      fired       = 1'b0;
      fire_at     = NO_FIRE;
      in_cycle    = cyc;
      in_mask     = mask;
      in_last     = last;
      in_is_store = mask ^ 4'b0110;
      for (int g = 0; g < 4; g++) begin
         in_address[64*g +: 64] = addr0 + 64'(g) * 64'h100;
         in_size[32*g +: 32]    = 32'(g + 1);
         in_data[64*g +: 64]    = ~addr0 ^ 64'(g);
      end
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !fired; i++) begin
         if (in_ready) begin
            fired   = 1'b1;
            fire_at = tb_cnt;
            if (exp_fire != NO_FIRE) begin
               e.fire = exp_fire;
               e.mask = mask;
               e.addr = in_address;
               e.st   = in_is_store;
               e.size = in_size;
               e.data = in_data;
               exp_q.push_back(e);
            end
         end
         step();
      end
      in_valid = 1'b0;
      if (!fired) chk("push_timeout", in_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] fa;
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_cycle    = '0;
      in_mask     = '0;
      in_address  = '0;
      in_is_store = '0;
      in_size     = '0;
      in_data     = '0;
      in_last     = 1'b0;
      req_ready   = 1'b0;

      // Single record due at cycle 5, marked last.
      do_reset();
      req_ready = 1'b1;
      push(64'd5, 4'b0001, 64'h1000, 1'b1, 64'd5, fa);
      wait_until(64'd4);
      chk("t1_early_valid", req_valid, 4'b0000);
      wait_until(64'd5);
      chk("t1_valid_at_5", req_valid, 4'b0001);
      chk("t1_done_at_5", done, 1'b0);
      wait_until(64'd6);
      chk("t1_valid_after", req_valid, 4'b0000);
      chk("t1_done_at_6", done, 1'b1);
      wait_until(64'd8);
      chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

      // Two records due at cycle 3 with backpressure over cycles 3..6.
      do_reset();
      push(64'd3, 4'b0011, 64'h2000, 1'b0, 64'd7, fa);
      push(64'd3, 4'b1100, 64'h3000, 1'b0, 64'd8, fa);
      wait_until(64'd3);
      chk("t2_valid_at_3", req_valid, 4'b0011);
      wait_until(64'd7);
      chk("t2_addr_held", req_address[63:0], 64'h2000);
      req_ready = 1'b1;
      wait_until(64'd10);
      chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef MEM_TRACE_DRIVER_STATS_EN
      chk("t2_stall_cycles", stall_cycles, 32'd4);
`endif

      // Fill the FIFO; the fifth record waits for the first pop at cycle 100.
      do_reset();
      req_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push(64'd100 + 64'(k), 4'b1111, 64'h4000 + 64'(k) * 64'h10, 1'b0, 64'd100 + 64'(k), fa);
      end
      chk("t3_full_in_ready", in_ready, 1'b0);
      push(64'd104, 4'b1010, 64'h5000, 1'b0, 64'd104, fa);
      chk("t3_fifth_accept_cycle", fa, 64'd100);
      wait_until(64'd106);
      chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

      // Late record: target 0 reaches the FIFO at cycle 50, issues at 51.
      do_reset();
      req_ready = 1'b1;
      wait_until(64'd49);
      push(64'd0, 4'b0110, 64'h6000, 1'b0, 64'd51, fa);
      wait_until(64'd53);
      chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef MEM_TRACE_DRIVER_STATS_EN
      chk("t4_late_records", late_records, 32'd1);
`endif

      // Zero-mask final record: never requests, done the cycle after its pop.
      do_reset();
      req_ready = 1'b1;
      push(64'd0, 4'b0000, 64'h7000, 1'b1, NO_FIRE, fa);
      chk("t5_done_at_1", done, 1'b0);
      wait_until(64'd2);
      chk("t5_done_at_2", done, 1'b1);
      chk("t5_in_ready_done", in_ready, 1'b0);
      wait_until(64'd6);
      chk("t5_done_sticky", done, 1'b1);
      chk("t5_req_valid", req_valid, 4'b0000);

      // Reset while a request is stalled; the counter restarts and nothing stale reappears.
      do_reset();
      push(64'd10, 4'b0001, 64'h8000, 1'b0, NO_FIRE, fa);
      wait_until(64'd10);
      chk("t6_valid_at_10", req_valid, 4'b0001);
      reset = 1'b1;
      step();
      chk("t6_valid_in_reset", req_valid, 4'b0000);
      chk("t6_in_ready_in_reset", in_ready, 1'b0);
      reset = 1'b0;
      #1;
      chk("t6_valid_after_reset", req_valid, 4'b0000);
      req_ready = 1'b1;
      push(64'd4, 4'b0100, 64'h9000, 1'b0, 64'd4, fa);
      wait_until(64'd20);
      chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_trace_driver.md
MEM_TRACE_DRIVER -- requirements
Module: mem_trace_driver

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 4, meaning the number of SIMT lanes per record.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, at least 2), meaning the number of buffered trace records.
REQ-003 The block SHALL have port clock, input, 1 bit, the clock; reset is reset, synchronous, active-high; clock is clock.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, record offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, record accepted (FIFO not full).
REQ-007 The block SHALL have port in_cycle, input, 64 bits, target issue cycle.
REQ-008 The block SHALL have port in_mask, input, NUM_LANES bits, per-lane valid, with LSB as lane 0.
REQ-009 The block SHALL have port in_address, input, 64*NUM_LANES bits, per-lane address, with lane g at bits [64g+63:64g].
REQ-010 The block SHALL have port in_is_store, input, NUM_LANES bits, per-lane store flag.
REQ-011 The block SHALL have port in_size, input, 32*NUM_LANES bits, per-lane log2 size.
REQ-012 The block SHALL have port in_data, input, 64*NUM_LANES bits, per-lane store data.
REQ-013 The block SHALL have port in_last, input, 1 bit, marking the record as the final trace record.
REQ-014 The block SHALL have output ports req_valid (NUM_LANES), req_address, req_is_store, req_size and req_data, packed identically to the in_* ports.
REQ-015 The block SHALL have port req_ready, input, 1 bit, a single ready shared by all lanes.
REQ-016 The block SHALL have port done, output, 1 bit, asserted once the last record has issued.

Function
REQ-017 A 64-bit cycle_counter SHALL be 0 in the first cycle after reset deasserts, increment by 1 every non-reset cycle, and wrap modulo 2^64.
REQ-018 The record fire SHALL occur when in_valid && in_ready; the FIFO SHALL accept fires in order and never drop or duplicate records.
REQ-019 The FSM SHALL have the following states: IDLE (FIFO empty), WAIT (head present, not eligible), ISSUE (output register valid), DONE.
REQ-020 A head record SHALL be eligible when (cycle_counter+1) >= head.cycle, compared unsigned, so that req_valid first rises in the cycle where cycle_counter == head.cycle.
REQ-021 A head whose cycle is already past (late) SHALL issue on the next cycle without error.
REQ-022 On load, the head SHALL move to the output register and req_valid SHALL equal head.mask.
REQ-023 The output register SHALL hold stable until req_fire = (|req_valid) && req_ready.
REQ-024 On req_fire, if the next head is eligible, it SHALL load in the same cycle with no bubble; otherwise the FSM SHALL go to WAIT or IDLE.
REQ-025 A record with mask 0 SHALL be popped in one cycle without asserting req_valid, and its in_last SHALL still count.
REQ-026 done SHALL assert in the cycle after the req_fire (or zero-mask pop) of the in_last record, and SHALL remain asserted (DONE is absorbing until reset).
REQ-027 In DONE, in_ready SHALL be 0.
REQ-028 A simultaneous FIFO push and pop when full SHALL NOT be allowed: in_ready SHALL depend only on occupancy.
REQ-029 A simultaneous push and pop when empty SHALL NOT bypass: the record SHALL be eligible one cycle after the push at the earliest.

Reset
REQ-030 Reset SHALL clear FIFO occupancy, cycle_counter, the output register valid bits, and done, and SHALL set the state to IDLE.
REQ-031 Reset outputs SHALL be: in_ready=0 during reset and 1 after, req_valid=0, done=0, and all req_* data fields=0.
REQ-032 Reset mid-ISSUE SHALL drop the pending request without a req_fire.

Configuration
REQ-033 When MEM_TRACE_DRIVER_STATS_EN is defined, the block SHALL add outputs stall_cycles (32 bits, counting cycles with |req_valid && !req_ready) and late_records (32 bits, counting loads where head.cycle < cycle_counter+1); both SHALL saturate at all-ones and be cleared by reset.
REQ-034 When MEM_TRACE_DRIVER_STATS_EN is undefined, the stall_cycles and late_records ports and their logic SHALL be absent.

Structure
REQ-035 Package mem_trace_pkg SHALL hold the ADDR_W=64, DATA_W=64, SIZE_W=32 and CYCLE_W=64 constants, the state enum, and the per-lane record struct.
REQ-036 A sub-module mem_trace_fifo (a parameterised synchronous FIFO with full/empty outputs) SHALL hold the record storage.

Verification
REQ-037 Reset then push {cycle=5, mask=4'b0001, addr0=0x1000}, with req_ready=1: req_valid=0001 exactly when cycle_counter==5, for 1 cycle.
REQ-038 Push cycle=3 and cycle=3 (same target), with req_ready low for 4 cycles then high: first request held stable with unchanged address, second issues in the cycle immediately after the first fire.
REQ-039 Fill 4 records with targets 100..103 and attempt a fifth push: in_ready=0 on the fifth attempt, and the fifth record is accepted after the first pop.
REQ-040 Push cycle=0 at counter 50 (late): issue at counter 51, and with MEM_TRACE_DRIVER_STATS_EN late_records=1.
REQ-041 Push a mask=0 record with in_last=1: req_valid stays 0 and done=1 in the next cycle.
REQ-042 Assert reset during ISSUE at cycle 10: req_valid=0 and cycle_counter=0 after release, and no stale request reappears.
